// File: rtl/clk_reset_seq.sv
// Reset sequencer and clock-enable generator behind the board PLL.
// Optional build macro LOCK_LOSS_REARM_EN: lock loss in RUN re-enters WAIT and sets lock_lost.
module clk_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CE_DIV             = 4,
  parameter int PIX_DIV            = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       cpu_ce,
  output logic       pix_ce,
  output logic       running,
  output logic [1:0] state,
  output logic       lock_lost
);

  localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int CPU_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_STABLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CPU_W-1:0] CPU_LAST = CPU_W'(CE_DIV - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);

  logic             sync1_q;
  logic             locked_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             sys_reset_q, sys_reset_d;
  logic [CPU_W-1:0] cpu_div_q, cpu_div_d;
  logic [PIX_W-1:0] pix_div_q, pix_div_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             pix_ce_q, pix_ce_d;
  logic             run_next;

  // Two-flop synchroniser for the asynchronous LOCKED input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (locked_s_q) begin
          state_d    = ST_STABLE;
          stab_cnt_d = '0;
        end
      end
      ST_STABLE: begin
        // Any low sample of the synchronised lock restarts qualification.
        if (!locked_s_q) begin
          state_d    = ST_WAIT;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef LOCK_LOSS_REARM_EN
        if (!locked_s_q) begin
          state_d    = ST_WAIT;
          stab_cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d    = ST_WAIT;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Dividers restart from 0 on the first RUN cycle so both strobes stay phase-aligned.
  always_comb begin
    run_next    = (state_d == ST_RUN);
    sys_reset_d = !run_next;
    cpu_div_d   = '0;
    pix_div_d   = '0;
    if (run_next && (state_q == ST_RUN)) begin
      cpu_div_d = (cpu_div_q == CPU_LAST) ? '0 : cpu_div_q + 1'b1;
      pix_div_d = (pix_div_q == PIX_LAST) ? '0 : pix_div_q + 1'b1;
    end
    cpu_ce_d = run_next && (cpu_div_d == CPU_LAST);
    pix_ce_d = run_next && (pix_div_d == PIX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sys_reset_q <= 1'b1;
      cpu_div_q   <= '0;
      pix_div_q   <= '0;
      cpu_ce_q    <= 1'b0;
      pix_ce_q    <= 1'b0;
    end else begin
      sys_reset_q <= sys_reset_d;
      cpu_div_q   <= cpu_div_d;
      pix_div_q   <= pix_div_d;
      cpu_ce_q    <= cpu_ce_d;
      pix_ce_q    <= pix_ce_d;
    end
  end

`ifdef LOCK_LOSS_REARM_EN
  logic lock_lost_q, lock_lost_d;

  assign lock_lost_d = lock_lost_q || ((state_q == ST_RUN) && (state_d == ST_WAIT));

  always_ff @(posedge clk) begin
    if (reset) lock_lost_q <= 1'b0;
    else       lock_lost_q <= lock_lost_d;
  end

  assign lock_lost = lock_lost_q;
`else
  assign lock_lost = 1'b0;
`endif

  assign sys_reset = sys_reset_q;
  assign cpu_ce    = cpu_ce_q;
  assign pix_ce    = pix_ce_q;
  assign running   = (state_q == ST_RUN);
  assign state     = state_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq: bring-up, lock drop in RUN, mid-run reset, STABLE glitch.
// A second instance with CE_DIV=1 shares the stimulus to cover the divide-by-1 case.
module tb_clk_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset, cpu_ce, pix_ce, running, lock_lost;
  logic [1:0] state;
  logic       d1_sys_reset, d1_cpu_ce, d1_pix_ce, d1_running, d1_lock_lost;
  logic [1:0] d1_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int exp_st;
  int rc;
  int exp_ll;

  clk_reset_seq #(.LOCK_STABLE_CYCLES(8), .CE_DIV(4), .PIX_DIV(2)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .sys_reset(sys_reset), .cpu_ce(cpu_ce), .pix_ce(pix_ce),
    .running(running), .state(state), .lock_lost(lock_lost)
  );

  clk_reset_seq #(.LOCK_STABLE_CYCLES(8), .CE_DIV(1), .PIX_DIV(2)) dut_div1 (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .sys_reset(d1_sys_reset), .cpu_ce(d1_cpu_ce), .pix_ce(d1_pix_ce),
    .running(d1_running), .state(d1_state), .lock_lost(d1_lock_lost)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs from the state the bench predicts and the RUN-cycle index rc (1 = first RUN cycle).
  task automatic check_all(input string tag, input int st, input int run_cyc, input int ll);
    int in_run;
    in_run = (st == 2) ? 1 : 0;
    check({tag, "_state"},     int'(state),     st);
    check({tag, "_sys_reset"}, int'(sys_reset), 1 - in_run);
    check({tag, "_running"},   int'(running),   in_run);
    check({tag, "_cpu_ce"},    int'(cpu_ce),    (in_run == 1 && run_cyc % 4 == 0) ? 1 : 0);
    check({tag, "_pix_ce"},    int'(pix_ce),    (in_run == 1 && run_cyc % 2 == 0) ? 1 : 0);
    check({tag, "_lock_lost"}, int'(lock_lost), ll);
    check({tag, "_div1_cpu_ce"}, int'(d1_cpu_ce), in_run);
    check({tag, "_div1_state"},  int'(d1_state),  st);
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Reset for three edges, then idle without lock.
    repeat (3) tick();
    check_all("reset_vals", 0, 0, 0);
    reset = 1'b0;
    while (cyc < 9) begin
      tick();
      check_all("wait_nolock", 0, 0, 0);
    end

    // Lock rises before edge 10: STABLE after 12, RUN after 20.
    pll_locked = 1'b1;
    while (cyc < 31) begin
      tick();
      exp_st = (cyc < 12) ? 0 : (cyc < 20) ? 1 : 2;
      check_all("bringup", exp_st, cyc - 19, 0);
    end

    // Lock drops for edges 32..35, restored before edge 36.
    pll_locked = 1'b0;
    while (cyc < 46) begin
      tick();
      if (cyc == 35) pll_locked = 1'b1;
`ifdef LOCK_LOSS_REARM_EN
      exp_st = (cyc < 34) ? 2 : (cyc < 38) ? 0 : (cyc < 46) ? 1 : 2;
      rc     = (cyc < 34) ? cyc - 19 : cyc - 45;
      exp_ll = (cyc >= 34) ? 1 : 0;
`else
      exp_st = 2;
      rc     = cyc - 19;
      exp_ll = 0;
`endif
      check_all("lockdrop", exp_st, rc, exp_ll);
    end

    // Reset in RUN with lock held: cleared after one edge, RUN again 11 edges after release.
    reset = 1'b1;
    tick();
    check_all("reset_mid", 0, 0, 0);
    reset = 1'b0;
    while (cyc < 58) begin
      tick();
      exp_st = (cyc < 50) ? 0 : (cyc < 58) ? 1 : 2;
      check_all("requal", exp_st, cyc - 57, 0);
    end

    // Re-enter STABLE, then drop lock for the single edge 67 while stab_cnt is 5.
    reset = 1'b1;
    tick();
    check_all("reset_again", 0, 0, 0);
    reset = 1'b0;
    while (cyc < 86) begin
      tick();
      if (cyc == 66) pll_locked = 1'b0;
      if (cyc == 67) pll_locked = 1'b1;
      exp_st = (cyc < 62) ? 0 : (cyc < 69) ? 1 : (cyc < 70) ? 0 : (cyc < 78) ? 1 : 2;
      check_all("glitch", exp_st, cyc - 77, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
